// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle ADD/COMP/AND/XOR, iterative one-bit-per-cycle shifts.
// Ports: clk, rst (sync, active-high); request a/b/c_in/op with in_valid/in_ready;
//        registered result and flags (c_out, zero, neg, ovf, err) with out_valid/out_ready.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_COMP = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_SHL  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_SRA  = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   count;
    logic [2:0]       op_q;

    logic [SHW-1:0]   shamt;
    logic             is_shift;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] acc_res;
    logic             acc_c;
    logic             acc_ovf;
    logic             acc_err;
    logic [WIDTH-1:0] sh_next;
    logic             sh_bit;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign shamt    = b[SHW-1:0];
    assign is_shift = (op == OP_SHL) || (op == OP_SHR) || (op == OP_SRA);
    assign add_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};

    // Result and flags of the single-cycle ops, taken straight from the inputs
    always_comb begin
        acc_res = '0;
        acc_c   = 1'b0;
        acc_ovf = 1'b0;
        acc_err = 1'b0;
        case (op)
            OP_ADD: begin
                acc_res = add_sum[WIDTH-1:0];
                acc_c   = add_sum[WIDTH];
                // operands agree in sign but the sum does not
                acc_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_COMP: begin
                acc_res = ~b + {{(WIDTH-1){1'b0}}, 1'b1};
                acc_c   = (b == '0);
                acc_ovf = (b == {1'b1, {(WIDTH-1){1'b0}}});
            end
            OP_AND:  acc_res = a & b;
            OP_XOR:  acc_res = a ^ b;
            OP_SHL, OP_SHR, OP_SRA: acc_res = '0;
            default: acc_err = 1'b1;
        endcase
    end

    // One-position shift of the working register and the bit it drops
    always_comb begin
        sh_next = work;
        sh_bit  = 1'b0;
        case (op_q)
            OP_SHL: begin
                sh_next = {work[WIDTH-2:0], 1'b0};
                sh_bit  = work[WIDTH-1];
            end
            OP_SHR: begin
                sh_next = {1'b0, work[WIDTH-1:1]};
                sh_bit  = work[0];
            end
            OP_SRA: begin
                sh_next = {work[WIDTH-1], work[WIDTH-1:1]};
                sh_bit  = work[0];
            end
            default: begin
                sh_next = work;
                sh_bit  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            work   <= '0;
            count  <= '0;
            op_q   <= '0;
            result <= '0;
            c_out  <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            ovf    <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= op;
                        if (is_shift) begin
                            work  <= a;
                            count <= shamt;
                            if (shamt == '0) begin
                                result <= a;
                                c_out  <= 1'b0;
                                zero   <= (a == '0);
                                neg    <= a[WIDTH-1];
                                ovf    <= 1'b0;
                                err    <= 1'b0;
                                state  <= DONE;
                            end else begin
                                state <= SHIFT;
                            end
                        end else begin
                            result <= acc_res;
                            c_out  <= acc_c;
                            zero   <= (acc_res == '0);
                            neg    <= acc_res[WIDTH-1];
                            ovf    <= acc_ovf;
                            err    <= acc_err;
                            state  <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    work  <= sh_next;
                    count <= count - 1'b1;
                    // final step: publish the shifted value and last bit out
                    if (count == {{(SHW-1){1'b0}}, 1'b1}) begin
                        result <= sh_next;
                        c_out  <= sh_bit;
                        zero   <= (sh_next == '0);
                        neg    <= sh_next[WIDTH-1];
                        ovf    <= 1'b0;
                        err    <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; legal values are powers of two, 4..64.
REQ-002 SHALL have derived localparam SHW = clog2(WIDTH): shift-amount width.
REQ-003 SHALL have clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have in_valid  input  1  operation request.
REQ-006 SHALL have in_ready  output  1  unit can accept a request.
REQ-007 SHALL have a  input  WIDTH  operand A.
REQ-008 SHALL have b  input  WIDTH  operand B; b[SHW-1:0] is the shift amount (shamt) for shift ops.
REQ-009 SHALL have c_in  input  1  carry-in, used by ADD only.
REQ-010 SHALL have op  input  3  opcode: 0 ADD, 1 COMP, 2 AND, 3 XOR, 4 SHL, 5 SHR (logical), 6 SRA, 7 illegal.
REQ-011 SHALL have out_valid  output  1  result available.
REQ-012 SHALL have out_ready  input  1  consumer accepts result.
REQ-013 SHALL have result  output  WIDTH  registered result.
REQ-014 SHALL have c_out, zero, neg, ovf, err  output  1 each  registered flags.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready=1 only in IDLE.
REQ-016 Accept SHALL occur on an edge with in_valid&in_ready; a, b, c_in, op latched at that edge; inputs ignored at all other times.
REQ-017 ADD: result=a+b+c_in mod 2^WIDTH; c_out=carry out of MSB; ovf=signed overflow.
REQ-018 COMP: result=~b+1; c_out=1 iff b==0; ovf=1 iff b==1<<(WIDTH-1).
REQ-019 AND: result=a&b; XOR: result=a^b; c_out=ovf=0.
REQ-020 Ops 0-3 and 7 SHALL go IDLE->DONE at accept edge (latency 1: out_valid high in the cycle after accept).
REQ-021 Shifts SHALL be iterative, one bit position per cycle: at accept, working reg=a, count=shamt; shamt!=0 -> SHIFT, shamt==0 -> DONE with result=a, c_out=0.
REQ-022 In SHIFT, each edge SHALL shift working reg by one (SHL: zero fill at LSB; SHR: zero fill at MSB; SRA: replicate MSB) and decrement count; edge at which count goes 1->0 transitions to DONE.
REQ-023 Shift latency SHALL be 1+shamt cycles; c_out = last bit shifted out; ovf=0.
REQ-024 op 7: result=0, err=1, other flags 0; err=0 for ops 0-6.
REQ-025 zero=(result==0), neg=result[WIDTH-1], for every op, computed from final result.
REQ-026 In DONE, out_valid=1; result and all flags SHALL hold stable until an edge with out_ready=1, which returns FSM to IDLE and drops out_valid.
REQ-027 No new accept in DONE or SHIFT; next accept earliest one cycle after result handoff (in_ready rises after handoff edge).
REQ-028 out_ready SHALL be ignored outside DONE; result/flags SHALL retain last delivered values while IDLE.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, count=0, result=0, all flags 0, out_valid=0, in_ready=1 after that edge, regardless of state.
REQ-030 rst SHALL take priority over accept and handoff in the same cycle; an operation in SHIFT or DONE is discarded, no partial result delivered.

Verification (WIDTH=32)
REQ-031 ADD a=0x7FFFFFFF b=0x00000001 c_in=0 -> one cycle later out_valid=1, result=0x80000000, ovf=1, neg=1, c_out=0, zero=0.
REQ-032 COMP b=0 -> result=0x00000000, c_out=1, zero=1, ovf=0; COMP b=0x80000000 -> result=0x80000000, ovf=1.
REQ-033 SRA a=0x80000000 b=4 -> out_valid exactly 5 cycles after accept, result=0xF8000000, c_out=0; SHR same operands -> 0x08000000.
REQ-034 SHL a=0x80000001 b=1 -> latency 2, result=0x00000002, c_out=1; out_ready held 0 for 3 cycles -> result/flags stable, in_ready=0, in_valid pulses ignored.
REQ-035 SHL b=31 accepted, rst pulsed during SHIFT -> after reset edge out_valid=0, in_ready=1, result=0; a following AND a=0xF0F0F0F0 b=0xFF00FF00 -> 0xF000F000 with latency 1.
REQ-036 op=7 any operands -> result=0, err=1, zero=1, latency 1; next ADD clears err.
